overlay_compositor: RTL and testbench
=====================================

# overlay_compositor

Pipelined, parametrised video overlay stage between the frame-buffer read path and the VGA output. It draws a scalable ROI border and a row of colour swatches showing the current and most recent detected dice colours, and blinks the border after each new RED/GREEN/BLUE result. Detection state is committed only at frame boundaries, so the overlay never tears mid-frame. The output is registered with a fixed 2-cycle latency.

## Interface
- SCALE_SHIFT, 1: ROI coordinates are in source space; VGA bound = param << SCALE_SHIFT (0 = 1:1, 1 = 320x240 on 640x480).
- ROI_X_START / ROI_X_END / ROI_Y_START / ROI_Y_END, 100 / 220 / 60 / 180: ROI rectangle in source space, end exclusive.
- BOX_THICKNESS, 2: border thickness in source pixels; scaled like the ROI bounds.
- HIST_DEPTH, 4: number of swatches; slot 0 shows the current result.
- IND_X / IND_Y, 10 / 10: top-left of slot 0, in VGA space.
- SWATCH_SIZE / SWATCH_GAP, 30 / 4: swatch edge length and horizontal spacing, in VGA pixels.
- BLINK_FRAMES, 8: frames the border blinks after a new colour result.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- x_coord, y_coord  in  10  VGA coordinates.
- display_enable  in  1  active video.
- frame_start  in  1  one-cycle pulse per frame, asserted during vertical blanking.
- pixel_r_in / pixel_g_in / pixel_b_in  in  4 each  source pixel.
- dominant_color  in  2  0 = NONE, 1 = RED, 2 = GREEN, 3 = BLUE.
- white_detected  in  1  level signal; overrides dominant_color.
- pixel_r_out / pixel_g_out / pixel_b_out  out  4 each  registered output pixel.
- de_out  out  1  display_enable delayed by 2 cycles.

## Operation
- Class code (3 bits): NONE = 0, RED = 1, GREEN = 2, BLUE = 3, WHITE = 4. WHITE is selected when white_detected = 1.
- Class colours (RGB444): NONE 444, RED F00, GREEN 0F0, BLUE 00F, WHITE FFF.
- On frame_start, sample the class code:
  - If it differs from hist[0]: shift hist[i] → hist[i+1], discard the oldest entry, and write the new code to hist[0].
  - If the new code is RED, GREEN or BLUE: load blink_cnt = BLINK_FRAMES.
  - Otherwise, if blink_cnt ≠ 0: decrement blink_cnt.
- Swatch i region: x in [IND_X + i·(SWATCH_SIZE + SWATCH_GAP), +SWATCH_SIZE), y in [IND_Y, IND_Y + SWATCH_SIZE). Fill colour = class colour of hist[i].
- ROI border: the scaled left, right, top and bottom bands, each inside the scaled ROI rectangle.
- Border colour:
  - Colour of hist[0] when blink_cnt ≠ 0 and blink_cnt[1] = 1.
  - Yellow (FF0) otherwise.
- Priority: swatch > border > pass-through.
- Outside display_enable the output is 000.
- Width rules:
  - All bounds are computed at elaboration in 11 bits.
  - Elaboration fails if any scaled bound exceeds 640/480, or if the last swatch exceeds 640.
  - Run-time comparisons are 10-bit unsigned.

## Timing
- Stage 1 registers:
  - swatch hit and index,
  - border hit,
  - the resolved overlay colour, read from hist in this stage,
  - input pixel and display_enable.
- Stage 2 registers the output mux.
- Latency is exactly 2 cycles for pixel and de_out. The sync generator must delay hsync/vsync by 2 cycles.
- A history change is visible on pixels that enter stage 1 on or after the cycle following frame_start. Pixels already in the pipeline keep their old colour.
- If frame_start coincides with display_enable (misuse), the same rule still applies.
- Reset values: hist[*] = NONE, blink_cnt = 0, both pipeline stages = 0, so pixel outputs = 000 and de_out = 0. These hold for 2 cycles after reset deasserts.
- Reset asserted mid-frame clears all of the above on the next edge.

## Structure
- Package overlay_pkg holds:
  - color_class_t enum (3 bits),
  - rgb444_t struct,
  - class_to_rgb function,
  - detector 2-bit encoding constants.
- Sub-module overlay_history contains the frame-synchronous history shift register and the blink counter. Outputs: hist array, blink_on.
- The top level contains region decode and the 2-stage pipeline.

## Test plan
- Reset, then run one full frame with dominant_color = 0 → de_out follows display_enable by 2 cycles; pixel (15,15) = 444; pixel (200,120) with SCALE_SHIFT = 1 = FF0.
- Pass-through: input pixel A5C at (300,300) with display_enable = 1 → output A5C exactly 2 cycles later; display_enable = 0 → output 000.
- Set RED then frame_start → slot 0 = F00, slot 1 = 444. The border alternates F00/FF0 every 2 frames for 8 frames, then stays FF0.
- Sequence RED, GREEN, BLUE, WHITE, RED across 5 frames → slots 0–3 = F00, FFF, 00F, 0F0. RED is pushed again because it differs from hist[0].
- Change dominant_color mid-frame without frame_start → no output change until the next frame_start.
- Assert reset mid-line → outputs 000 and de_out = 0 for 2 cycles after release; history all 444.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared types and helpers for the video overlay compositor.
// Class codes, RGB444 pixel struct and detector encoding.
package overlay_pkg;

   typedef enum logic [2:0] {
      CLS_NONE  = 3'd0,
      CLS_RED   = 3'd1,
      CLS_GREEN = 3'd2,
      CLS_BLUE  = 3'd3,
      CLS_WHITE = 3'd4
   } color_class_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   localparam logic [1:0] DET_NONE  = 2'd0;
   localparam logic [1:0] DET_RED   = 2'd1;
   localparam logic [1:0] DET_GREEN = 2'd2;
   localparam logic [1:0] DET_BLUE  = 2'd3;

   localparam rgb444_t RGB_YELLOW = '{4'hF, 4'hF, 4'h0};

   function automatic rgb444_t class_to_rgb(input color_class_t c);
      rgb444_t v;
      case (c)
         CLS_RED:   v = '{4'hF, 4'h0, 4'h0};
         CLS_GREEN: v = '{4'h0, 4'hF, 4'h0};
         CLS_BLUE:  v = '{4'h0, 4'h0, 4'hF};
         CLS_WHITE: v = '{4'hF, 4'hF, 4'hF};
         default:   v = '{4'h4, 4'h4, 4'h4};
      endcase
      return v;
   endfunction

endpackage

// File: rtl/overlay_history.sv
// Frame-synchronous colour history and border blink counter.
// State only changes on frame_start, so the overlay never tears.
module overlay_history
   import overlay_pkg::*;
#(
   parameter int HIST_DEPTH   = 4,
   parameter int BLINK_FRAMES = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         frame_start,
   input  logic [1:0]   dominant_color,
   input  logic         white_detected,
   output color_class_t hist [HIST_DEPTH],
   output logic         blink_on
);

   localparam int CWR = $clog2(BLINK_FRAMES + 1);
   localparam int CW  = (CWR < 2) ? 2 : CWR;

   logic [CW-1:0] blink_cnt;
   color_class_t  code;
   logic          changed;
   logic          is_rgb;

   always_comb begin
      code = CLS_NONE;
      if (white_detected) code = CLS_WHITE;
      else code = color_class_t'({1'b0, dominant_color});
      changed = (code != hist[0]);
      is_rgb  = (code == CLS_RED) || (code == CLS_GREEN)
             || (code == CLS_BLUE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= CLS_NONE;
         blink_cnt <= '0;
      end else if (frame_start) begin
         if (changed) begin
            hist[0] <= code;
            for (int i = 1; i < HIST_DEPTH; i++) hist[i] <= hist[i-1];
         end
         // only a fresh colour result restarts the blink
         if (changed && is_rgb) blink_cnt <= CW'(BLINK_FRAMES);
         else if (blink_cnt != '0) blink_cnt <= blink_cnt - 1'b1;
      end
   end

   assign blink_on = (blink_cnt != '0) && blink_cnt[1];

endmodule

// File: rtl/overlay_compositor.sv
// Two-stage overlay pipeline: ROI border and history swatches
// composited over the frame-buffer pixel stream.
module overlay_compositor
   import overlay_pkg::*;
#(
   parameter int SCALE_SHIFT   = 1,
   parameter int ROI_X_START   = 100,
   parameter int ROI_X_END     = 220,
   parameter int ROI_Y_START   = 60,
   parameter int ROI_Y_END     = 180,
   parameter int BOX_THICKNESS = 2,
   parameter int HIST_DEPTH    = 4,
   parameter int IND_X         = 10,
   parameter int IND_Y         = 10,
   parameter int SWATCH_SIZE   = 30,
   parameter int SWATCH_GAP    = 4,
   parameter int BLINK_FRAMES  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] x_coord,
   input  logic [9:0] y_coord,
   input  logic       display_enable,
   input  logic       frame_start,
   input  logic [3:0] pixel_r_in,
   input  logic [3:0] pixel_g_in,
   input  logic [3:0] pixel_b_in,
   input  logic [1:0] dominant_color,
   input  logic       white_detected,
   output logic [3:0] pixel_r_out,
   output logic [3:0] pixel_g_out,
   output logic [3:0] pixel_b_out,
   output logic       de_out
);

   localparam int IW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
   localparam int PITCH = SWATCH_SIZE + SWATCH_GAP;
   localparam int LAST_SW_END = IND_X + (HIST_DEPTH - 1) * PITCH + SWATCH_SIZE;

   localparam logic [10:0] RX0 = 11'(ROI_X_START << SCALE_SHIFT);
   localparam logic [10:0] RX1 = 11'(ROI_X_END << SCALE_SHIFT);
   localparam logic [10:0] RY0 = 11'(ROI_Y_START << SCALE_SHIFT);
   localparam logic [10:0] RY1 = 11'(ROI_Y_END << SCALE_SHIFT);
   localparam logic [10:0] TH  = 11'(BOX_THICKNESS << SCALE_SHIFT);
   localparam logic [10:0] BX0 = RX0 + TH;
   localparam logic [10:0] BX1 = RX1 - TH;
   localparam logic [10:0] BY0 = RY0 + TH;
   localparam logic [10:0] BY1 = RY1 - TH;
   localparam logic [10:0] SY0 = 11'(IND_Y);
   localparam logic [10:0] SY1 = 11'(IND_Y + SWATCH_SIZE);

   if ((ROI_X_END << SCALE_SHIFT) > 640 || (ROI_Y_END << SCALE_SHIFT) > 480)
   begin : g_bad_roi
      $error("overlay_compositor: scaled ROI exceeds 640x480");
   end
   if (LAST_SW_END > 640 || IND_Y + SWATCH_SIZE > 480) begin : g_bad_sw
      $error("overlay_compositor: swatch row exceeds 640x480");
   end

   color_class_t hist [HIST_DEPTH];
   logic         blink_on;

   overlay_history #(
      .HIST_DEPTH   (HIST_DEPTH),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_hist (
      .clk            (clk),
      .reset          (reset),
      .frame_start    (frame_start),
      .dominant_color (dominant_color),
      .white_detected (white_detected),
      .hist           (hist),
      .blink_on       (blink_on)
   );

   logic [HIST_DEPTH-1:0] sw_vec;
   logic                  y_in_sw;

   assign y_in_sw = (y_coord >= SY0[9:0]) && (y_coord < SY1[9:0]);

   for (genvar i = 0; i < HIST_DEPTH; i++) begin : g_sw
      localparam logic [10:0] SX0 = 11'(IND_X + i * PITCH);
      localparam logic [10:0] SX1 = 11'(IND_X + i * PITCH + SWATCH_SIZE);
      assign sw_vec[i] = y_in_sw && (x_coord >= SX0[9:0])
                      && (x_coord < SX1[9:0]);
   end

   logic          sw_hit;
   logic [IW-1:0] sw_idx;
   logic          in_roi;
   logic          bd_hit;
   rgb444_t       ov_color;

   always_comb begin
      sw_idx = '0;
      for (int i = HIST_DEPTH - 1; i >= 0; i--)
         if (sw_vec[i]) sw_idx = IW'(i);
      sw_hit = |sw_vec;
      in_roi = (x_coord >= RX0[9:0]) && (x_coord < RX1[9:0])
            && (y_coord >= RY0[9:0]) && (y_coord < RY1[9:0]);
      bd_hit = in_roi && ((x_coord < BX0[9:0]) || (x_coord >= BX1[9:0])
            || (y_coord < BY0[9:0]) || (y_coord >= BY1[9:0]));
      if (sw_hit) ov_color = class_to_rgb(hist[sw_idx]);
      else if (blink_on) ov_color = class_to_rgb(hist[0]);
      else ov_color = RGB_YELLOW;
   end

   logic    s1_sw;
   logic    s1_bd;
   logic    s1_de;
   rgb444_t s1_ov;
   rgb444_t s1_pix;
   rgb444_t s2_pix;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_sw  <= 1'b0;
         s1_bd  <= 1'b0;
         s1_de  <= 1'b0;
         s1_ov  <= '0;
         s1_pix <= '0;
         s2_pix <= '0;
         de_out <= 1'b0;
      end else begin
         s1_sw  <= sw_hit;
         s1_bd  <= bd_hit;
         s1_de  <= display_enable;
         s1_ov  <= ov_color;
         s1_pix <= '{pixel_r_in, pixel_g_in, pixel_b_in};
         de_out <= s1_de;
         if (!s1_de) s2_pix <= '0;
         else if (s1_sw || s1_bd) s2_pix <= s1_ov;
         else s2_pix <= s1_pix;
      end
   end

   assign pixel_r_out = s2_pix.r;
   assign pixel_g_out = s2_pix.g;
   assign pixel_b_out = s2_pix.b;

endmodule

// File: tb/tb_overlay_compositor.sv
// Directed bench for overlay_compositor with default parameters.
// Outputs are checked #1 after the rising edge.
module tb_overlay_compositor;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] x_coord;
   logic [9:0] y_coord;
   logic       display_enable;
   logic       frame_start;
   logic [3:0] pixel_r_in;
   logic [3:0] pixel_g_in;
   logic [3:0] pixel_b_in;
   logic [1:0] dominant_color;
   logic       white_detected;
   logic [3:0] pixel_r_out;
   logic [3:0] pixel_g_out;
   logic [3:0] pixel_b_out;
   logic       de_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   overlay_compositor dut (
      .clk            (clk),
      .reset          (reset),
      .x_coord        (x_coord),
      .y_coord        (y_coord),
      .display_enable (display_enable),
      .frame_start    (frame_start),
      .pixel_r_in     (pixel_r_in),
      .pixel_g_in     (pixel_g_in),
      .pixel_b_in     (pixel_b_in),
      .dominant_color (dominant_color),
      .white_detected (white_detected),
      .pixel_r_out    (pixel_r_out),
      .pixel_g_out    (pixel_g_out),
      .pixel_b_out    (pixel_b_out),
      .de_out         (de_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [12:0] exp);
      logic [12:0] obs;
      obs = {de_out, pixel_r_out, pixel_g_out, pixel_b_out};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int px, input int py, input logic d,
                        input logic [11:0] rgb);
      x_coord = 10'(px);
      y_coord = 10'(py);
      display_enable = d;
      {pixel_r_in, pixel_g_in, pixel_b_in} = rgb;
   endtask

   task automatic pix(input string tag, input int px, input int py,
                      input logic [11:0] exp);
      drive(px, py, 1'b1, 12'h123);
      step();
      step();
      check(tag, {1'b1, exp});
   endtask

   task automatic frame(input logic [1:0] dom, input logic wh);
      drive(0, 500, 1'b0, 12'h000);
      dominant_color = dom;
      white_detected = wh;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   logic [11:0] blink_exp [9];

   initial begin
      blink_exp = '{12'hF00, 12'hF00, 12'hFF0, 12'hFF0, 12'hF00,
                    12'hF00, 12'hFF0, 12'hFF0, 12'hFF0};
      reset = 1'b1;
      frame_start = 1'b0;
      dominant_color = 2'd0;
      white_detected = 1'b0;
      drive(0, 0, 1'b0, 12'h000);
      step();
      step();
      step();
      check("reset_state", 13'h0000);

      reset = 1'b0;
      drive(300, 300, 1'b1, 12'hA5C);
      step();
      check("latency_1cyc", 13'h0000);
      step();
      check("passthru", {1'b1, 12'hA5C});
      drive(300, 300, 1'b0, 12'hA5C);
      step();
      step();
      check("blanked", 13'h0000);

      frame(2'd0, 1'b0);
      pix("slot0_none", 15, 15, 12'h444);
      pix("border_tl", 200, 120, 12'hFF0);
      pix("roi_inner", 210, 200, 12'h123);
      pix("border_left", 203, 200, 12'hFF0);
      pix("border_right", 439, 200, 12'hFF0);
      pix("roi_right_out", 440, 200, 12'h123);
      pix("border_bottom", 300, 359, 12'hFF0);

      frame(2'd1, 1'b0);
      pix("red_slot0", 15, 15, 12'hF00);
      pix("red_slot1", 50, 15, 12'h444);
      pix("red_gap", 42, 15, 12'h123);
      pix("blink_load", 200, 120, 12'hFF0);
      for (int k = 0; k < 9; k++) begin
         frame(2'd1, 1'b0);
         pix($sformatf("blink%0d", k + 1), 200, 120, blink_exp[k]);
      end

      frame(2'd2, 1'b0);
      frame(2'd3, 1'b0);
      frame(2'd0, 1'b1);
      frame(2'd1, 1'b0);
      pix("seq_slot0", 15, 15, 12'hF00);
      pix("seq_slot1", 50, 15, 12'hFFF);
      pix("seq_slot2", 85, 15, 12'h00F);
      pix("seq_slot3", 120, 15, 12'h0F0);

      dominant_color = 2'd2;
      pix("midframe_hold", 15, 15, 12'hF00);
      pix("midframe_hold_b", 200, 120, 12'hFF0);

      drive(15, 15, 1'b1, 12'h123);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      check("misuse_old", {1'b1, 12'hF00});
      step();
      check("misuse_new", {1'b1, 12'h0F0});
      pix("misuse_slot1", 50, 15, 12'hF00);

      drive(300, 300, 1'b1, 12'hA5C);
      step();
      step();
      reset = 1'b1;
      step();
      check("rst_mid", 13'h0000);
      reset = 1'b0;
      step();
      check("rst_hold", 13'h0000);
      step();
      check("rst_release", {1'b1, 12'hA5C});
      pix("rst_slot0", 15, 15, 12'h444);
      pix("rst_slot1", 50, 15, 12'h444);
      pix("rst_slot2", 85, 15, 12'h444);
      pix("rst_slot3", 120, 15, 12'h444);
      pix("rst_border", 200, 120, 12'hFF0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
